imm_gen_stage: RTL

//  Registered RV immediate-generation stage with valid/ready handshake, generalised to XLEN 32/64.

---
 rtl/imm_pkg.sv | 33 +++
 rtl/imm_gen_stage_decode.sv | 59 +++++
 rtl/imm_gen_stage.sv | 75 +++++++
 3 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: opcode constants, format encodings and the registered bundle type for imm_gen_stage.
package imm_pkg;
    localparam int XLEN_MAX = 64;

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    // Fields are sized for the widest XLEN; narrower stages use the low bits.
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        logic [2:0]          fmt;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] target;
        logic                illegal;
    } imm_bundle_t;
endpackage

// File: rtl/imm_gen_stage_decode.sv
// imm_decode: combinational RV immediate decode, inst -> {imm, fmt, illegal}.
// Define IMM_ILLEGAL_CHECK_EN to flag unknown opcodes and inst[1:0] != 2'b11 as illegal.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);
    logic [31:0] raw;
    logic [2:0]  dfmt;

    // Every immediate fits in 32 bits; widening to XLEN is a single sign extension.
    always_comb begin
        raw  = '0;
        dfmt = FMT_ILL;
        case (inst[6:2])
            OPC_OP: dfmt = FMT_R;
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                dfmt = FMT_I;
                raw  = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                dfmt = FMT_S;
                raw  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                dfmt = FMT_B;
                raw  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                dfmt = FMT_U;
                raw  = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                dfmt = FMT_J;
                raw  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: ;
        endcase
    end

`ifdef IMM_ILLEGAL_CHECK_EN
    logic bad;
    assign bad     = (dfmt == FMT_ILL) | (inst[1:0] != 2'b11);
    assign illegal = bad;
    assign fmt     = bad ? FMT_ILL : dfmt;
    assign imm     = bad ? '0 : XLEN'($signed(raw));
`else
    logic unused_lsb;
    assign unused_lsb = ^inst[1:0];
    assign illegal    = 1'b0;
    assign fmt        = dfmt;
    assign imm        = XLEN'($signed(raw));
`endif
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate-generation stage with valid/ready and optional 2-entry skid.
// Illegal-encoding detection is enabled by defining IMM_ILLEGAL_CHECK_EN (see imm_decode).
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] sum;
    logic [2:0]      fmt;
    logic            illegal;
    logic            out_v, skid_v, rdy_q, free, acc;
    imm_bundle_t     nxt, out_q, skid_q, out_n;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .imm     (imm),
        .fmt     (fmt),
        .illegal (illegal)
    );

    assign sum = in_pc + imm;
    assign nxt = '{imm: XLEN_MAX'(imm), fmt: fmt, pc: XLEN_MAX'(in_pc),
                   target: XLEN_MAX'(sum), illegal: illegal};

    // The skid entry only fills while the output is stalled, so with SKID=0 it stays empty.
    assign free     = !out_v | out_ready;
    assign in_ready = (SKID != 0) ? (rdy_q & !rst) : free;
    assign acc      = in_valid & in_ready;
    assign out_n    = (free & skid_v) ? skid_q : (free & acc) ? nxt : out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            out_v  <= free ? (skid_v | acc) : out_v;
            out_q  <= out_n;
            skid_v <= !free & (skid_v | acc);
            if (!free & acc) skid_q <= nxt;
            rdy_q  <= free | !(skid_v | acc);
        end
    end

    assign out_valid   = out_v;
    assign out_imm     = out_q.imm[XLEN-1:0];
    assign out_fmt     = out_q.fmt;
    assign out_pc      = out_q.pc[XLEN-1:0];
    assign out_target  = out_q.target[XLEN-1:0];
    assign out_illegal = out_q.illegal;

    if (XLEN < XLEN_MAX) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^{out_q.imm[XLEN_MAX-1:XLEN], out_q.pc[XLEN_MAX-1:XLEN],
                             out_q.target[XLEN_MAX-1:XLEN]};
    end
endmodule
